// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared types for the FP instruction encoder slice: RV FP support levels,
// the FP major opcodes, the decoded request bundle, field constants, the
// output-buffer state encoding and a helper that recognises the opcodes.
// ---------------------------------------------------------------------------
package fp_pkg;

  // How much floating-point support the core exposes
  typedef enum logic [1:0] {
    RV32FNone   = 2'd0,
    RV32FSingle = 2'd1,
    RV64FDouble = 2'd2
  } rvfloat_e;

  // Major opcodes of the RV F/D instruction forms
  typedef enum logic [6:0] {
    LOAD_FP  = 7'b0000111,
    STORE_FP = 7'b0100111,
    MADD     = 7'b1000011,
    MSUB     = 7'b1000111,
    NMSUB    = 7'b1001011,
    NMADD    = 7'b1001111,
    OP_FP    = 7'b1010011
  } opcode_e;

  // Precision field values (R/R4 forms) and load/store width funct3 values
  localparam logic [1:0] FMT_S  = 2'b00;
  localparam logic [1:0] FMT_D  = 2'b01;
  localparam logic [2:0] W_S    = 3'b010;
  localparam logic [2:0] W_D    = 3'b011;
  localparam logic [2:0] RM_DYN = 3'b111;

  // Decoded micro-op fields as presented to the encoder.
  // op is kept as raw bits because unknown opcodes must be reported, not lost.
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  rm;
    logic [1:0]  fmt;
    logic [4:0]  funct5;
    logic [11:0] imm;
  } enc_req_t;

  // Occupancy of the two-entry output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } bufstate_e;

  // True when op is one of the FP major opcodes
  function automatic logic isKnownOp(input logic [6:0] op);
    logic known;
    case (op)
      LOAD_FP, STORE_FP, MADD, MSUB, NMSUB, NMADD, OP_FP: known = 1'b1;
      default:                                           known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/fp_enc_fifo2.sv
// ---------------------------------------------------------------------------
// fp_enc_fifo2
// Generic two-entry elastic buffer with valid/ready on both sides. The head
// entry drives the outputs directly; a skid entry sits behind it. Input ready
// depends only on registered occupancy, so there is no combinational path
// from out_ready_i to in_ready_o or from the input data to the outputs.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i/in_ready_o    upstream handshake
//   in_data_i [W-1:0]        word to enqueue
//   out_valid_o/out_ready_i  downstream handshake
//   out_data_o [W-1:0]       head word, stable while stalled
// ---------------------------------------------------------------------------
module fp_enc_fifo2
  import fp_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  bufstate_e    r_state;
  bufstate_e    w_stateNext;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_push;
  logic         w_pop;
  logic         w_loadHead;
  logic         w_headFromSkid;
  logic         w_loadSkid;

  assign in_ready_o  = (r_state != BUF_FULL);
  assign out_valid_o = (r_state != BUF_EMPTY);
  assign out_data_o  = r_head;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  // Next occupancy and which storage entries load this cycle. A push and pop
  // together with one entry held simply replaces the head, keeping order.
  always_comb begin
    w_stateNext    = r_state;
    w_loadHead     = 1'b0;
    w_headFromSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_push) begin
          w_stateNext = BUF_ONE;
          w_loadHead  = 1'b1;
        end
      end
      BUF_ONE: begin
        if (w_push && w_pop) begin
          w_loadHead = 1'b1;
        end else if (w_push) begin
          w_stateNext = BUF_FULL;
          w_loadSkid  = 1'b1;
        end else if (w_pop) begin
          w_stateNext = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (w_pop) begin
          w_stateNext    = BUF_ONE;
          w_loadHead     = 1'b1;
          w_headFromSkid = 1'b1;
        end
      end
      default: w_stateNext = BUF_EMPTY;
    endcase
  end

  // State and storage registers; reset drops anything buffered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= BUF_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_loadHead) begin
        r_head <= w_headFromSkid ? r_skid : in_data_i;
      end
      if (w_loadSkid) begin
        r_skid <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/fp_instr_encoder.sv
// ---------------------------------------------------------------------------
// fp_instr_encoder
// Packs decoded FP micro-op fields into 32-bit RV F/D instruction words (the
// inverse of the FP decoder) behind a two-entry valid/ready output buffer,
// and keeps saturating counts of emitted and illegal words.
// Configuration macro: FP_ENC_DOUBLE_EN -- when defined, fmt=01 (double) is
// legal if RVF == RV64FDouble; when undefined, double forms are always illegal
// and no double-width logic is built.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   in_valid_i/in_ready_o           request handshake
//   op_i, rd_i, rs1_i, rs2_i, rs3_i opcode and register indices
//   rm_i, fmt_i, funct5_i, imm_i    rounding mode, precision, OP_FP funct5, offset
//   out_valid_o/out_ready_i         encoded word handshake
//   instr_o, illegal_o              encoded word (0 when illegal), illegal flag
//   enc_cnt_o, ill_cnt_o            saturating emitted / illegal word counts
// ---------------------------------------------------------------------------
module fp_instr_encoder
  import fp_pkg::*;
#(
  parameter rvfloat_e RVF   = RV32FSingle,
  parameter int       CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       op_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rs3_i,
  input  logic [2:0]       rm_i,
  input  logic [1:0]       fmt_i,
  input  logic [4:0]       funct5_i,
  input  logic [11:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  enc_req_t         w_req;
  logic             w_dblOk;
  logic [2:0]       w_width;
  logic             w_isR;
  logic             w_isR4;
  logic             w_illegal;
  logic [31:0]      w_instr;
  logic [32:0]      w_fifoOut;
  logic             w_outFire;
  logic [CNT_W-1:0] r_encCnt;
  logic [CNT_W-1:0] r_illCnt;

  assign w_req = {op_i, rd_i, rs1_i, rs2_i, rs3_i, rm_i, fmt_i, funct5_i, imm_i};

`ifdef FP_ENC_DOUBLE_EN
  assign w_dblOk = (RVF == RV64FDouble);
  assign w_width = (w_req.fmt == FMT_D) ? W_D : W_S;
`else
  // Double precision is never legal here, so loads/stores only ever use W_S
  assign w_dblOk = 1'b0;
  assign w_width = W_S;
`endif

  // Legality check and field packing for every instruction form. An illegal
  // request still produces a word, forced to zero, so it takes one slot.
  always_comb begin
    w_isR     = (w_req.op == OP_FP);
    w_isR4    = (w_req.op == MADD) || (w_req.op == MSUB) ||
                (w_req.op == NMSUB) || (w_req.op == NMADD);
    w_illegal = !isKnownOp(w_req.op)
              || ((w_req.fmt != FMT_S) && (w_req.fmt != FMT_D))
              || ((w_req.fmt == FMT_D) && !w_dblOk)
              || ((w_isR || w_isR4) && (w_req.rm > 3'b100) && (w_req.rm != RM_DYN))
              || (RVF == RV32FNone);
    w_instr   = '0;
    case (w_req.op)
      LOAD_FP:  w_instr = {w_req.imm, w_req.rs1, w_width, w_req.rd, w_req.op};
      STORE_FP: w_instr = {w_req.imm[11:5], w_req.rs2, w_req.rs1, w_width,
                           w_req.imm[4:0], w_req.op};
      MADD, MSUB, NMSUB, NMADD:
                w_instr = {w_req.rs3, w_req.fmt, w_req.rs2, w_req.rs1,
                           w_req.rm, w_req.rd, w_req.op};
      OP_FP:    w_instr = {w_req.funct5, w_req.fmt, w_req.rs2, w_req.rs1,
                           w_req.rm, w_req.rd, w_req.op};
      default:  w_instr = '0;
    endcase
    if (w_illegal) begin
      w_instr = '0;
    end
  end

  fp_enc_fifo2 #(
    .W(33)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   ({w_illegal, w_instr}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (w_fifoOut)
  );

  assign instr_o   = w_fifoOut[31:0];
  assign illegal_o = w_fifoOut[32];
  assign w_outFire = out_valid_o & out_ready_i;

  // Statistics count words as they leave; both stick at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_encCnt <= '0;
      r_illCnt <= '0;
    end else if (w_outFire) begin
      if (r_encCnt != '1) begin
        r_encCnt <= r_encCnt + 1'b1;
      end
      if (illegal_o && (r_illCnt != '1)) begin
        r_illCnt <= r_illCnt + 1'b1;
      end
    end
  end

  assign enc_cnt_o = r_encCnt;
  assign ill_cnt_o = r_illCnt;

endmodule

// File: tb/tb_fp_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_fp_instr_encoder
// Directed checks of the reference encodings, backpressure and mid-stream
// reset, then randomized traffic against an arithmetic reference model.
// A second instance with 2-bit counters exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_fp_instr_encoder;
  import fp_pkg::*;

  localparam int NRAND = 200;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i, rs3_i;
  logic [2:0]  rm_i;
  logic [1:0]  fmt_i;
  logic [4:0]  funct5_i;
  logic [11:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic        illegal_o;
  logic [15:0] enc_cnt_o;
  logic [15:0] ill_cnt_o;

  logic        satInReady, satOutValid, satIllegal;
  logic [31:0] satInstr;
  logic [1:0]  satEncCnt, satIllCnt;

  int errCount   = 0;
  int checkCount = 0;
  logic [32:0] expQ[$];

  always #5 clk_i = ~clk_i;

  fp_instr_encoder #(.RVF(RV32FSingle), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
    .rm_i(rm_i), .fmt_i(fmt_i), .funct5_i(funct5_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o),
    .illegal_o(illegal_o), .enc_cnt_o(enc_cnt_o), .ill_cnt_o(ill_cnt_o)
  );

  fp_instr_encoder #(.RVF(RV32FSingle), .CNT_W(2)) dutSat (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(satInReady),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
    .rm_i(rm_i), .fmt_i(fmt_i), .funct5_i(funct5_i), .imm_i(imm_i),
    .out_valid_o(satOutValid), .out_ready_i(out_ready_i), .instr_o(satInstr),
    .illegal_o(satIllegal), .enc_cnt_o(satEncCnt), .ill_cnt_o(satIllCnt)
  );

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Present one request on the input port (call at a negative edge)
  task automatic applyStimulus(input enc_req_t r);
    op_i = r.op; rd_i = r.rd; rs1_i = r.rs1; rs2_i = r.rs2; rs3_i = r.rs3;
    rm_i = r.rm; fmt_i = r.fmt; funct5_i = r.funct5; imm_i = r.imm;
    in_valid_i = 1'b1;
  endtask

  function automatic enc_req_t mkReq(int op, int rd, int rs1, int rs2, int rs3,
                                     int rm, int fmt, int f5, int imm);
    enc_req_t r;
    r.op = 7'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.rs3 = 5'(rs3); r.rm = 3'(rm); r.fmt = 2'(fmt); r.funct5 = 5'(f5);
    r.imm = 12'(imm);
    return r;
  endfunction

  // Reference encoder built from field positions with plain arithmetic.
  // Both instances run single-precision only, so only fmt=0 is legal.
  function automatic logic [32:0] refEncode(input enc_req_t r);
    longint op, rd, rs1, rs2, rs3, rm, fmt, f5, imm, word;
    bit isR, isR4, legal;
    op = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; rs3 = r.rs3;
    rm = r.rm; fmt = r.fmt; f5 = r.funct5; imm = r.imm;
    isR4  = (op == 67) || (op == 71) || (op == 75) || (op == 79);
    isR   = (op == 83);
    legal = (op == 7) || (op == 39) || isR || isR4;
    if (fmt != 0) legal = 0;
    if ((isR || isR4) && (rm == 5 || rm == 6)) legal = 0;
    if (!legal) return {1'b1, 32'h0};
    if (op == 7)
      word = imm * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + op;
    else if (op == 39)
      word = (imm / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
           + 2 * (1 << 12) + (imm % 32) * (1 << 7) + op;
    else if (isR4)
      word = rs3 * (1 << 27) + fmt * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
           + rm * (1 << 12) + rd * (1 << 7) + op;
    else
      word = f5 * (1 << 27) + fmt * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
           + rm * (1 << 12) + rd * (1 << 7) + op;
    return {1'b0, word[31:0]};
  endfunction

  function automatic enc_req_t randReq();
    enc_req_t r;
    int ops[7] = '{7, 39, 67, 71, 75, 79, 83};
    int pick;
    pick     = int'($urandom_range(0, 19));
    r.op     = (pick < 18) ? 7'(ops[pick % 7]) : 7'($urandom);
    r.rd     = 5'($urandom); r.rs1 = 5'($urandom);
    r.rs2    = 5'($urandom); r.rs3 = 5'($urandom);
    r.rm     = 3'($urandom);
    r.fmt    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    r.funct5 = 5'($urandom);
    r.imm    = 12'($urandom);
    return r;
  endfunction

  function automatic int satLimit(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  // One request through an idle encoder with the consumer always ready
  task automatic sendOne(input string tag, input enc_req_t r,
                         input logic [31:0] expInstr, input logic expIll);
    applyStimulus(r);
    checkOutput({tag, "_nocomb"}, 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    checkOutput({tag, "_instr"}, instr_o, expInstr);
    checkOutput({tag, "_ill"}, 32'(illegal_o), 32'(expIll));
    @(negedge clk_i);
  endtask

  enc_req_t reqA, reqB, reqC;
  logic [32:0] expA, expB, expC;

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    applyStimulus(mkReq(0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset_instr", instr_o, 32'd0);
    checkOutput("reset_ill", 32'(illegal_o), 32'd0);
    checkOutput("reset_enc", 32'(enc_cnt_o), 32'd0);
    checkOutput("reset_illcnt", 32'(ill_cnt_o), 32'd0);
    checkOutput("reset_ready", 32'(in_ready_o), 32'd1);

    out_ready_i = 1'b1;
    sendOne("fadd_s", mkReq(83, 1, 2, 3, 0, 0, 0, 0, 0), 32'h003100D3, 1'b0);
    sendOne("flw", mkReq(7, 5, 10, 0, 0, 0, 0, 0, 8), 32'h00852287, 1'b0);
    sendOne("fsw", mkReq(39, 0, 11, 6, 0, 0, 0, 0, 12), 32'h0065A627, 1'b0);
    sendOne("fmadd_s", mkReq(67, 1, 2, 3, 4, 0, 0, 0, 0), 32'h203100C3, 1'b0);
    checkOutput("enc_after4", 32'(enc_cnt_o), 32'd4);
    checkOutput("ill_before", 32'(ill_cnt_o), 32'd0);
    sendOne("fadd_d", mkReq(83, 1, 2, 3, 0, 0, 1, 0, 0), 32'h0, 1'b1);
    checkOutput("ill_after_d", 32'(ill_cnt_o), 32'd1);
    sendOne("rm101", mkReq(83, 1, 2, 3, 0, 5, 0, 0, 0), 32'h0, 1'b1);
    checkOutput("ill_after_rm", 32'(ill_cnt_o), 32'd2);
    checkOutput("enc_after6", 32'(enc_cnt_o), 32'd6);

    // Backpressure: three back-to-back requests with the consumer stalled
    reqA = mkReq(83, 7, 8, 9, 0, 1, 0, 1, 0);
    reqB = mkReq(7, 3, 4, 0, 0, 0, 0, 0, 100);
    reqC = mkReq(71, 12, 13, 14, 15, 7, 0, 0, 0);
    expA = refEncode(reqA); expB = refEncode(reqB); expC = refEncode(reqC);
    out_ready_i = 1'b0;
    applyStimulus(reqA);
    @(negedge clk_i); applyStimulus(reqB);
    @(negedge clk_i); applyStimulus(reqC);
    checkOutput("bp_full_ready", 32'(in_ready_o), 32'd0);
    checkOutput("bp_head_a", instr_o, expA[31:0]);
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("bp_hold_ready", 32'(in_ready_o), 32'd0);
      checkOutput("bp_hold_valid", 32'(out_valid_o), 32'd1);
      checkOutput("bp_hold_a", instr_o, expA[31:0]);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_head_b", instr_o, expB[31:0]);
    checkOutput("bp_ready_again", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checkOutput("bp_head_c", instr_o, expC[31:0]);
    checkOutput("bp_c_valid", 32'(out_valid_o), 32'd1);
    @(negedge clk_i);
    checkOutput("bp_drained", 32'(out_valid_o), 32'd0);
    checkOutput("bp_enc", 32'(enc_cnt_o), 32'd9);

    // Reset with two words buffered
    out_ready_i = 1'b0;
    applyStimulus(reqA);
    @(negedge clk_i); applyStimulus(reqB);
    @(negedge clk_i); in_valid_i = 1'b0;
    checkOutput("rst_pre_full", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_instr", instr_o, 32'd0);
    checkOutput("rst_enc", 32'(enc_cnt_o), 32'd0);
    checkOutput("rst_ill", 32'(ill_cnt_o), 32'd0);
    checkOutput("rst_ready", 32'(in_ready_o), 32'd1);

    // Randomized traffic with random stalls on both sides
    fork
      begin : driver
        int sent = 0;
        int cyc = 0;
        bit accepted = 0;
        enc_req_t cur;
        cur = mkReq(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (sent < NRAND && cyc < 4000) begin
          @(negedge clk_i);
          cyc++;
          if (accepted) begin
            in_valid_i = 1'b0;
            accepted = 0;
          end
          if (!in_valid_i && $urandom_range(0, 3) != 0) begin
            cur = randReq();
            applyStimulus(cur);
          end
          if (in_valid_i && in_ready_o) begin
            expQ.push_back(refEncode(cur));
            sent++;
            accepted = 1;
          end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        if (sent < NRAND) checkOutput("drv_timeout", 32'(sent), 32'(NRAND));
      end
      begin : monitor
        int got = 0;
        int cyc = 0;
        int modelEnc = 0;
        int modelIll = 0;
        bit stall = 0;
        logic [31:0] held = '0;
        logic [32:0] exp;
        while (got < NRAND && cyc < 5000) begin
          @(negedge clk_i);
          cyc++;
          checkOutput("rnd_enc_cnt", 32'(enc_cnt_o), 32'(modelEnc));
          checkOutput("rnd_ill_cnt", 32'(ill_cnt_o), 32'(modelIll));
          checkOutput("sat_enc_cnt", 32'(satEncCnt), 32'(satLimit(modelEnc, 3)));
          checkOutput("sat_ill_cnt", 32'(satIllCnt), 32'(satLimit(modelIll, 3)));
          if (stall) begin
            checkOutput("rnd_hold_valid", 32'(out_valid_o), 32'd1);
            checkOutput("rnd_hold_instr", instr_o, held);
          end
          out_ready_i = ($urandom_range(0, 2) != 0);
          stall = out_valid_o && !out_ready_i;
          held  = instr_o;
          if (out_valid_o && out_ready_i) begin
            if (expQ.size() == 0) begin
              checkOutput("rnd_unexpected", 32'(expQ.size()), 32'd1);
            end else begin
              exp = expQ.pop_front();
              checkOutput("rnd_instr", instr_o, exp[31:0]);
              checkOutput("rnd_ill", 32'(illegal_o), 32'(exp[32]));
            end
            got++;
            modelEnc++;
            if (illegal_o) modelIll++;
          end
        end
        if (got < NRAND) checkOutput("mon_timeout", 32'(got), 32'(NRAND));
        @(negedge clk_i);
        checkOutput("rnd_final_enc", 32'(enc_cnt_o), 32'(modelEnc));
        checkOutput("sat_final_enc", 32'(satEncCnt), 32'(satLimit(modelEnc, 3)));
      end
    join

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
